// File: rtl/mt_pkg.sv
// Constants shared by the Mersenne-Twister generator and its output-stream sink.
package mt_pkg;

  localparam int unsigned MT_WORD_W     = 32;
  localparam logic [31:0] MT_MATRIX_A   = 32'h9908B0DF;
  localparam int unsigned MT_N          = 624;
  localparam int unsigned MT_FIFO_DEPTH = 16;

endpackage

// File: rtl/mt_rn_sink_if.sv
// Stream-in and ready/valid read port of the MT output sink, plus its status/clear signals.
interface mt_rn_sink_if
  import mt_pkg::*;
#(
  parameter int unsigned DATA_W = MT_WORD_W,
  parameter int unsigned DEPTH  = MT_FIFO_DEPTH,
  parameter int unsigned DROP_W = 16
) ();

  localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

  logic [DATA_W-1:0] rn_in;
  logic              rn_valid_in;
  logic              rd_ready;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic [LVL_W-1:0]  level;
  logic              almost_full;
  logic              overflow;
  logic [DROP_W-1:0] drop_count;
  logic              clr_overflow;

  modport master (
    output rn_in, rn_valid_in, rd_ready, clr_overflow,
    input  rd_data, rd_valid, level, almost_full, overflow, drop_count
  );

  modport slave (
    input  rn_in, rn_valid_in, rd_ready, clr_overflow,
    output rd_data, rd_valid, level, almost_full, overflow, drop_count
  );

endinterface

// File: rtl/mt_rn_fifo_mem.sv
// Simple dual-port storage: synchronous write, asynchronous read. Contents are not reset.
module mt_rn_fifo_mem #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 16
) (
  input  logic                     clk_i,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [DATA_W-1:0]        wdata_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [DATA_W-1:0]        rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/mt_rn_sink.sv
// FIFO sink for the push-only MT word stream: never stalls the generator, drops and counts
// words that arrive while full, and re-presents buffered words on a fall-through read port.
module mt_rn_sink
  import mt_pkg::*;
#(
  parameter int unsigned DATA_W    = MT_WORD_W,
  parameter int unsigned DEPTH     = MT_FIFO_DEPTH,
  parameter int unsigned AF_THRESH = 12,
  parameter int unsigned DROP_W    = 16
) (
  input logic         clk,
  input logic         rst,
  mt_rn_sink_if.slave bus
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam logic [LW-1:0] LvlFull = LW'(DEPTH);
  localparam logic [LW-1:0] LvlAf   = LW'(AF_THRESH);

  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]     level_q, level_d;
  logic              overflow_q, overflow_d;
  logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;
  logic              push, pop, drop, not_empty;
  logic [DATA_W-1:0] mem_rdata;

  assign not_empty = (level_q != '0);

  always_comb begin
    pop  = not_empty & bus.rd_ready;
    // A pop frees the slot the same cycle, so a full FIFO still accepts a concurrent push.
    push = bus.rn_valid_in & ((level_q != LvlFull) | pop);
    drop = bus.rn_valid_in & ~push;

    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;

    level_d = level_q;
    if (push && !pop) begin
      level_d = level_q + LW'(1);
    end else if (pop && !push) begin
      level_d = level_q - LW'(1);
    end

    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;
    // A drop in the clearing cycle is counted as the first drop after the clear.
    if (drop) begin
      overflow_d = 1'b1;
      if (bus.clr_overflow) begin
        drop_cnt_d = DROP_W'(1);
      end else if (drop_cnt_q != '1) begin
        drop_cnt_d = drop_cnt_q + DROP_W'(1);
      end
    end else if (bus.clr_overflow) begin
      overflow_d = 1'b0;
      drop_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  mt_rn_fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk_i   (clk),
    .we_i    (push),
    .waddr_i (wr_ptr_q),
    .wdata_i (bus.rn_in),
    .raddr_i (rd_ptr_q),
    .rdata_o (mem_rdata)
  );

  assign bus.rd_valid    = not_empty;
  assign bus.rd_data     = not_empty ? mem_rdata : '0;
  assign bus.level       = level_q;
  assign bus.almost_full = (level_q >= LvlAf);
  assign bus.overflow    = overflow_q;
  assign bus.drop_count  = drop_cnt_q;

endmodule

// File: tb/tb_mt_rn_sink.sv
// Bench for mt_rn_sink: directed scenarios plus a randomized run against a queue-based model.
module tb_mt_rn_sink;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mt_rn_sink_if #(.DATA_W(32), .DEPTH(16), .DROP_W(16)) bus ();

  mt_rn_sink #(
    .DATA_W    (32),
    .DEPTH     (16),
    .AF_THRESH (12),
    .DROP_W    (16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Reference model: a queue of accepted words plus the drop bookkeeping.
  logic [31:0] q[$];
  int unsigned m_drops;
  bit          m_ovf;
  int          checks = 0;
  int          errors = 0;

  task automatic drive(input bit v, input logic [31:0] d, input bit r, input bit c);
    bit pop, push, drop;
    bus.rn_valid_in  = v;
    bus.rn_in        = d;
    bus.rd_ready     = r;
    bus.clr_overflow = c;
    pop  = (q.size() != 0) && r;
    push = v && ((q.size() < 16) || pop);
    drop = v && !push;
    if (pop) void'(q.pop_front());
    if (push) q.push_back(d);
    if (drop) begin
      m_ovf = 1'b1;
      if (c) m_drops = 1;
      else if (m_drops < 65535) m_drops++;
    end else if (c) begin
      m_ovf   = 1'b0;
      m_drops = 0;
    end
    @(posedge clk);
    #1;
    bus.rn_valid_in  = 1'b0;
    bus.rd_ready     = 1'b0;
    bus.clr_overflow = 1'b0;
  endtask

  task automatic test_reset();
    bus.rn_valid_in = 1'b0; bus.rn_in = '0; bus.rd_ready = 1'b0; bus.clr_overflow = 1'b0;
    rst = 1'b1;
    #12;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checks++; if (bus.rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid got %b want 0", bus.rd_valid); end
    checks++; if (bus.level !== 5'd0) begin errors++; $display("FAIL reset_level got %0d want 0", bus.level); end
    checks++; if (bus.rd_data !== 32'h0) begin errors++; $display("FAIL reset_rd_data got %h want 0", bus.rd_data); end
    checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b want 0", bus.overflow); end
    checks++; if (bus.drop_count !== 16'd0) begin errors++; $display("FAIL reset_drops got %0d want 0", bus.drop_count); end
    checks++; if (bus.almost_full !== 1'b0) begin errors++; $display("FAIL reset_af got %b want 0", bus.almost_full); end
  endtask

  task automatic test_basic();
    logic [31:0] exp [3];
    exp[0] = 32'h0000_1111; exp[1] = 32'h0000_2222; exp[2] = 32'h0000_3333;
    drive(1'b1, exp[0], 1'b0, 1'b0);
    checks++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== exp[0]) begin
      errors++; $display("FAIL basic_first got v=%b %h want v=1 %h", bus.rd_valid, bus.rd_data, exp[0]);
    end
    drive(1'b1, exp[1], 1'b0, 1'b0);
    drive(1'b1, exp[2], 1'b0, 1'b0);
    checks++; if (bus.level !== 5'd3) begin errors++; $display("FAIL basic_level got %0d want 3", bus.level); end
    checks++; if (bus.rd_data !== exp[0]) begin errors++; $display("FAIL basic_hold got %h want %h", bus.rd_data, exp[0]); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (bus.rd_data !== exp[i]) begin
        errors++; $display("FAIL basic_pop%0d got %h want %h", i, bus.rd_data, exp[i]);
      end
      drive(1'b0, '0, 1'b1, 1'b0);
    end
    checks++; if (bus.rd_valid !== 1'b0) begin errors++; $display("FAIL basic_empty got %b want 0", bus.rd_valid); end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 20; i++) begin
      checks++; if (bus.almost_full !== ((i < 16 ? i : 16) >= 12)) begin
        errors++; $display("FAIL ovf_af%0d got %b want %b", i, bus.almost_full, (i < 16 ? i : 16) >= 12);
      end
      drive(1'b1, 32'hA000_0000 + 32'(i), 1'b0, 1'b0);
    end
    checks++; if (bus.level !== 5'd16) begin errors++; $display("FAIL ovf_level got %0d want 16", bus.level); end
    checks++; if (bus.overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b want 1", bus.overflow); end
    checks++; if (bus.drop_count !== 16'd4) begin errors++; $display("FAIL ovf_drops got %0d want 4", bus.drop_count); end
    for (int i = 0; i < 16; i++) begin
      checks++; if (bus.rd_data !== 32'hA000_0000 + 32'(i)) begin
        errors++; $display("FAIL ovf_drain%0d got %h want %h", i, bus.rd_data, 32'hA000_0000 + 32'(i));
      end
      drive(1'b0, '0, 1'b1, 1'b0);
    end
    checks++; if (bus.rd_valid !== 1'b0) begin errors++; $display("FAIL ovf_empty got %b want 0", bus.rd_valid); end
  endtask

  task automatic test_back_to_back();
    drive(1'b0, '0, 1'b0, 1'b1);
    checks++; if (bus.drop_count !== 16'd0) begin errors++; $display("FAIL b2b_clr got %0d want 0", bus.drop_count); end
    for (int i = 0; i < 16; i++) drive(1'b1, 32'hB000_0000 + 32'(i), 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      checks++; if (bus.level !== 5'd16 || bus.rd_data !== 32'hB000_0000 + 32'(i)) begin
        errors++; $display("FAIL b2b_pass%0d got lvl=%0d %h want lvl=16 %h", i, bus.level, bus.rd_data, 32'hB000_0000 + 32'(i));
      end
      drive(1'b1, 32'hB000_0010 + 32'(i), 1'b1, 1'b0);
    end
    checks++; if (bus.level !== 5'd16) begin errors++; $display("FAIL b2b_level got %0d want 16", bus.level); end
    checks++; if (bus.drop_count !== 16'd0 || bus.overflow !== 1'b0) begin
      errors++; $display("FAIL b2b_drops got %0d/%b want 0/0", bus.drop_count, bus.overflow);
    end
    for (int i = 0; i < 16; i++) begin
      checks++; if (bus.rd_data !== 32'hB000_000A + 32'(i)) begin
        errors++; $display("FAIL b2b_drain%0d got %h want %h", i, bus.rd_data, 32'hB000_000A + 32'(i));
      end
      drive(1'b0, '0, 1'b1, 1'b0);
    end
  endtask

  task automatic test_clear();
    for (int i = 0; i < 20; i++) drive(1'b1, 32'hC000_0000 + 32'(i), 1'b0, 1'b0);
    checks++; if (bus.drop_count !== 16'd4) begin errors++; $display("FAIL clr_pre got %0d want 4", bus.drop_count); end
    drive(1'b1, 32'hC0DE_0000, 1'b0, 1'b1);
    checks++; if (bus.overflow !== 1'b1 || bus.drop_count !== 16'd1) begin
      errors++; $display("FAIL clr_dropwins got %b/%0d want 1/1", bus.overflow, bus.drop_count);
    end
    drive(1'b0, '0, 1'b0, 1'b1);
    checks++; if (bus.overflow !== 1'b0 || bus.drop_count !== 16'd0) begin
      errors++; $display("FAIL clr_plain got %b/%0d want 0/0", bus.overflow, bus.drop_count);
    end
    for (int i = 0; i < 16; i++) drive(1'b0, '0, 1'b1, 1'b0);
    checks++; if (bus.level !== 5'd0) begin errors++; $display("FAIL clr_drain got %0d want 0", bus.level); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      checks++;
      if (bus.level !== 5'(q.size()) || bus.rd_valid !== (q.size() != 0) ||
          bus.rd_data !== (q.size() != 0 ? q[0] : 32'h0) ||
          bus.almost_full !== (q.size() >= 12) || bus.overflow !== m_ovf ||
          bus.drop_count !== 16'(m_drops)) begin
        errors++;
        $display("FAIL rand%0d got lvl=%0d d=%h af=%b ovf=%b drops=%0d want lvl=%0d d=%h af=%b ovf=%b drops=%0d",
                 n, bus.level, bus.rd_data, bus.almost_full, bus.overflow, bus.drop_count,
                 q.size(), (q.size() != 0 ? q[0] : 32'h0), q.size() >= 12, m_ovf, m_drops);
      end
      drive($urandom_range(9, 0) < 7, $urandom, $urandom_range(9, 0) < 4,
            $urandom_range(31, 0) == 0);
    end
  endtask

  task automatic test_async_reset();
    while (q.size() != 0) drive(1'b0, '0, 1'b1, 1'b0);
    for (int i = 0; i < 7; i++) drive(1'b1, 32'hD000_0000 + 32'(i), 1'b0, 1'b0);
    checks++; if (bus.level !== 5'd7) begin errors++; $display("FAIL arst_pre got %0d want 7", bus.level); end
    bus.rn_valid_in = 1'b1; bus.rn_in = 32'hD000_0007;
    #2;
    rst = 1'b1;
    #1;
    checks++; if (bus.level !== 5'd0 || bus.rd_valid !== 1'b0 || bus.rd_data !== 32'h0) begin
      errors++; $display("FAIL arst_now got lvl=%0d v=%b d=%h want 0/0/0", bus.level, bus.rd_valid, bus.rd_data);
    end
    bus.rn_valid_in = 1'b0;
    q.delete(); m_drops = 0; m_ovf = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    drive(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0);
    checks++; if (bus.rd_data !== 32'hDEAD_BEEF || bus.level !== 5'd1) begin
      errors++; $display("FAIL arst_first got %h lvl=%0d want deadbeef lvl=1", bus.rd_data, bus.level);
    end
    drive(1'b1, 32'h1234_5678, 1'b1, 1'b0);
    checks++; if (bus.rd_data !== 32'h1234_5678 || bus.level !== 5'd1) begin
      errors++; $display("FAIL arst_second got %h lvl=%0d want 12345678 lvl=1", bus.rd_data, bus.level);
    end
  endtask

  initial begin
    m_drops = 0;
    m_ovf   = 1'b0;
    test_reset();
    test_basic();
    test_overflow();
    test_back_to_back();
    test_clear();
    test_random();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
